// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// uart_pkg: shared receiver types and constants (FSM state encoding, frame data width)
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  localparam int DATA_BITS = 8;
endpackage

// File: rtl/uart_rx_if.sv
`timescale 1ns/1ps
// uart_rx_if: serial line in, received byte and strobes out
//   rx_in    serial line, idles high
//   rx_out   last correctly framed byte
//   rx_valid one-cycle pulse when rx_out updates
//   rx_err   one-cycle pulse on a framing error
//   master = line driver / byte consumer, slave = receiver
interface uart_rx_if;
  import uart_pkg::*;
  logic                 rx_in;
  logic [DATA_BITS-1:0] rx_out;
  logic                 rx_valid;
  logic                 rx_err;
  modport master (output rx_in, input rx_out, rx_valid, rx_err);
  modport slave (input rx_in, output rx_out, rx_valid, rx_err);
endinterface

// File: rtl/uart_sync2.sv
`timescale 1ns/1ps
// uart_sync2: two-flop synchronizer, resets to 1 so an idle line never looks like a start bit
//   rx_clk clock, rx_rst sync active-high reset, i_d async input, o_q synchronized output
module uart_sync2 (
  input  logic rx_clk,
  input  logic rx_rst,
  input  logic i_d,
  output logic o_q
);
  logic [1:0] r_sync;
  always_ff @(posedge rx_clk)
    r_sync <= rx_rst ? 2'b11 : {r_sync[0], i_d};
  assign o_q = r_sync[1];
endmodule

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx: 8N1 serial receiver sampling each bit at its midpoint
//   rx_clk clock, rx_rst sync active-high reset
//   bus.rx_in serial line in; bus.rx_out held last good byte;
//   bus.rx_valid byte strobe; bus.rx_err framing-error strobe
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 521
) (
  input logic      rx_clk,
  input logic      rx_rst,
  uart_rx_if.slave bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] TOP = 3'(DATA_BITS - 1);
  state_t               r_state, w_state;
  logic [CW-1:0]        r_cnt, w_cnt;
  logic [2:0]           r_idx, w_idx;
  logic [DATA_BITS-1:0] r_shift, w_shift, r_out, w_out;
  logic                 r_valid, w_valid, r_err, w_err;
  logic                 w_rxs;
  uart_sync2 u_sync (.rx_clk(rx_clk), .rx_rst(rx_rst), .i_d(bus.rx_in), .o_q(w_rxs));
  always_ff @(posedge rx_clk)
    if (rx_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_idx   <= w_idx;
      r_shift <= w_shift;
      r_out   <= w_out;
      r_valid <= w_valid;
      r_err   <= w_err;
    end
  // START waits half a bit so every later full-bit wait lands mid-bit;
  // STOP leaves at mid-stop-bit so a following start edge is never missed.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt + 1'b1;
    w_idx   = r_idx;
    w_shift = r_shift;
    w_out   = r_out;
    w_valid = 1'b0;
    w_err   = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt   = '0;
        w_state = w_rxs ? IDLE : START;
      end
      START:
        if (r_cnt == HALF) begin
          w_cnt   = '0;
          w_state = w_rxs ? IDLE : DATA;
        end
      DATA:
        if (r_cnt == LAST) begin
          w_cnt          = '0;
          w_shift[r_idx] = w_rxs;
          w_idx          = r_idx + 3'd1;
          w_state        = (r_idx == TOP) ? STOP : DATA;
        end
      STOP:
        if (r_cnt == LAST) begin
          w_cnt   = '0;
          w_out   = w_rxs ? r_shift : r_out;
          w_valid = w_rxs;
          w_err   = ~w_rxs;
          w_state = w_rxs ? IDLE : BREAK;
        end
      BREAK: begin
        w_cnt   = '0;
        w_state = w_rxs ? IDLE : BREAK;
      end
      default: begin
        w_cnt   = '0;
        w_state = IDLE;
      end
    endcase
  end
  assign bus.rx_out   = r_out;
  assign bus.rx_valid = r_valid;
  assign bus.rx_err   = r_err;
endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// tb_uart_rx: directed self-checking bench for uart_rx
module tb_uart_rx;
  import uart_pkg::*;
  localparam int CPB = 521;
  localparam int BIT_NS = 10416;
  logic clk = 1'b0;
  logic rst = 1'b1;
  uart_rx_if bus();
  uart_rx #(.CLKS_PER_BIT(CPB)) dut (.rx_clk(clk), .rx_rst(rst), .bus(bus));
  always #10 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_err = 0;
  bit both = 1'b0;
  time t_valid = 0;
  logic [7:0] hist[$];
  always @(negedge clk) begin
    if (bus.rx_valid) begin
      n_valid++;
      t_valid = $time;
      hist.push_back(bus.rx_out);
    end
    if (bus.rx_err) n_err++;
    if (bus.rx_valid && bus.rx_err) both = 1'b1;
  end
  task automatic send_byte(input logic [7:0] b, input logic stop);
    bus.rx_in = 1'b0;
    #BIT_NS;
    for (int i = 0; i < 8; i++) begin
      bus.rx_in = b[i];
      #BIT_NS;
    end
    bus.rx_in = stop;
    #BIT_NS;
  endtask
  task automatic idle_bits(input int n);
    bus.rx_in = 1'b1;
    #(n * BIT_NS);
  endtask
  task automatic test_reset;
    rst = 1'b1;
    bus.rx_in = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.rx_out !== 8'h00) begin errors++; $display("FAIL reset_out got %h exp 00", bus.rx_out); end
    checks++;
    if (bus.rx_valid !== 1'b0 || bus.rx_err !== 1'b0) begin errors++; $display("FAIL reset_strobes got v%b e%b exp v0 e0", bus.rx_valid, bus.rx_err); end
    checks++;
    if (dut.r_state !== IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", dut.r_state, IDLE); end
    checks++;
    if (dut.u_sync.r_sync !== 2'b11) begin errors++; $display("FAIL reset_sync got %b exp 11", dut.u_sync.r_sync); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask
  task automatic test_basic;
    int v0, e0;
    time t_fall;
    v0 = n_valid;
    e0 = n_err;
    @(negedge clk);
    t_fall = $time;
    send_byte(8'hE3, 1'b1);
    idle_bits(1);
    checks++;
    if (n_valid - v0 != 1) begin errors++; $display("FAIL basic_valid got %0d exp 1", n_valid - v0); end
    checks++;
    if (bus.rx_out !== 8'hE3) begin errors++; $display("FAIL basic_out got %h exp e3", bus.rx_out); end
    checks++;
    if (n_err != e0) begin errors++; $display("FAIL basic_err got %0d exp 0", n_err - e0); end
    checks++;
    if ((t_valid - t_fall) / 20 < 4950 || (t_valid - t_fall) / 20 > 4956) begin
      errors++; $display("FAIL basic_latency got %0d exp 4950..4956", (t_valid - t_fall) / 20);
    end
  endtask
  task automatic test_extremes;
    int v0, e0;
    v0 = n_valid;
    e0 = n_err;
    @(negedge clk);
    send_byte(8'h00, 1'b1);
    idle_bits(1);
    checks++;
    if (n_valid - v0 != 1 || bus.rx_out !== 8'h00) begin errors++; $display("FAIL ext_00 got n%0d %h exp n1 00", n_valid - v0, bus.rx_out); end
    send_byte(8'hFF, 1'b1);
    idle_bits(1);
    checks++;
    if (n_valid - v0 != 2 || bus.rx_out !== 8'hFF) begin errors++; $display("FAIL ext_ff got n%0d %h exp n2 ff", n_valid - v0, bus.rx_out); end
    checks++;
    if (n_err != e0) begin errors++; $display("FAIL ext_err got %0d exp 0", n_err - e0); end
  endtask
  task automatic test_back_to_back;
    int v0, e0;
    v0 = n_valid;
    e0 = n_err;
    @(negedge clk);
    send_byte(8'h55, 1'b1);
    send_byte(8'hAA, 1'b1);
    idle_bits(1);
    checks++;
    if (n_valid - v0 != 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", n_valid - v0); end
    checks++;
    if (hist.size() < 2 || hist[hist.size()-2] !== 8'h55) begin errors++; $display("FAIL b2b_first got %h exp 55", hist.size() >= 2 ? hist[hist.size()-2] : 8'hxx); end
    checks++;
    if (bus.rx_out !== 8'hAA) begin errors++; $display("FAIL b2b_out got %h exp aa", bus.rx_out); end
    checks++;
    if (n_err != e0) begin errors++; $display("FAIL b2b_err got %0d exp 0", n_err - e0); end
  endtask
  task automatic test_glitch;
    int v0, e0;
    v0 = n_valid;
    e0 = n_err;
    @(negedge clk);
    bus.rx_in = 1'b0;
    repeat (100) @(negedge clk);
    bus.rx_in = 1'b1;
    repeat (400) @(negedge clk);
    checks++;
    if (n_valid != v0 || n_err != e0) begin errors++; $display("FAIL glitch_strobes got v%0d e%0d exp v0 e0", n_valid - v0, n_err - e0); end
    checks++;
    if (dut.r_state !== IDLE) begin errors++; $display("FAIL glitch_state got %0d exp %0d", dut.r_state, IDLE); end
    checks++;
    if (bus.rx_out !== 8'hAA) begin errors++; $display("FAIL glitch_out got %h exp aa", bus.rx_out); end
  endtask
  task automatic test_framing;
    int v0, e0;
    v0 = n_valid;
    e0 = n_err;
    @(negedge clk);
    send_byte(8'h3C, 1'b0);
    #(2 * BIT_NS);
    checks++;
    if (dut.r_state !== BREAK) begin errors++; $display("FAIL frm_break got %0d exp %0d", dut.r_state, BREAK); end
    checks++;
    if (n_err - e0 != 1 || n_valid != v0) begin errors++; $display("FAIL frm_strobes got e%0d v%0d exp e1 v0", n_err - e0, n_valid - v0); end
    checks++;
    if (bus.rx_out !== 8'hAA) begin errors++; $display("FAIL frm_out got %h exp aa", bus.rx_out); end
    idle_bits(1);
    checks++;
    if (dut.r_state !== IDLE) begin errors++; $display("FAIL frm_idle got %0d exp %0d", dut.r_state, IDLE); end
    send_byte(8'h81, 1'b1);
    idle_bits(1);
    checks++;
    if (n_valid - v0 != 1 || bus.rx_out !== 8'h81) begin errors++; $display("FAIL frm_next got n%0d %h exp n1 81", n_valid - v0, bus.rx_out); end
    checks++;
    if (n_err - e0 != 1) begin errors++; $display("FAIL frm_errcount got %0d exp 1", n_err - e0); end
  endtask
  task automatic test_mid_reset;
    int v0, e0;
    logic [7:0] b;
    v0 = n_valid;
    e0 = n_err;
    b = 8'h96;
    @(negedge clk);
    bus.rx_in = 1'b0;
    #BIT_NS;
    for (int i = 0; i < 4; i++) begin
      bus.rx_in = b[i];
      #BIT_NS;
    end
    bus.rx_in = b[4];
    #(BIT_NS / 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.rx_out !== 8'h00) begin errors++; $display("FAIL mrst_out got %h exp 00", bus.rx_out); end
    checks++;
    if (dut.r_state !== IDLE) begin errors++; $display("FAIL mrst_state got %0d exp %0d", dut.r_state, IDLE); end
    idle_bits(2);
    checks++;
    if (n_valid != v0 || n_err != e0 || bus.rx_out !== 8'h00) begin
      errors++; $display("FAIL mrst_quiet got v%0d e%0d %h exp v0 e0 00", n_valid - v0, n_err - e0, bus.rx_out);
    end
    send_byte(8'h5A, 1'b1);
    idle_bits(1);
    checks++;
    if (n_valid - v0 != 1 || bus.rx_out !== 8'h5A) begin errors++; $display("FAIL mrst_next got n%0d %h exp n1 5a", n_valid - v0, bus.rx_out); end
    checks++;
    if (n_err != e0) begin errors++; $display("FAIL mrst_err got %0d exp 0", n_err - e0); end
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end
  initial begin
    bus.rx_in = 1'b1;
    test_reset;
    test_basic;
    test_extremes;
    test_back_to_back;
    test_glitch;
    test_framing;
    test_mid_reset;
    checks++;
    if (both !== 1'b0) begin errors++; $display("FAIL exclusive_strobes got %b exp 0", both); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
